// File: rtl/gate_pkg.sv
// Shared types and constants for the parking-gate sequencer.
package gate_pkg;

  // Gate controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    PASSING = 2'd2,
    CLOSING = 2'd3
  } gate_state_e;

  // Passage direction encoding shared with the occupancy counter.
  localparam logic DIR_IN  = 1'b1;
  localparam logic DIR_OUT = 1'b0;

  // Width of a counter that runs from 0 to n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gate_sequencer_if.sv
// Detector, sensor and gate-control signals between the sequencer and its environment.
interface gate_sequencer_if;
  logic entry_req;
  logic exit_req;
  logic pass_sensor;
  logic full;
  logic gate_open;
  logic evt_pulse;
  logic evt_dir;
  logic deny;
  logic busy;

  // Environment side: drives detectors and occupancy status, observes the gate.
  modport master (
    output entry_req, exit_req, pass_sensor, full,
    input  gate_open, evt_pulse, evt_dir, deny, busy
  );

  // Sequencer side.
  modport slave (
    input  entry_req, exit_req, pass_sensor, full,
    output gate_open, evt_pulse, evt_dir, deny, busy
  );
endinterface

// File: rtl/gate_sequencer_debounce.sv
// Level debouncer: the filtered output follows the raw input only after the raw
// input has held the new level for DEBOUNCE_CYC consecutive cycles. The raw input
// is expected to be already synchronous to clk.
module debounce
  import gate_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);

  localparam int             W    = cnt_width(DEBOUNCE_CYC);
  localparam logic [W-1:0]   LAST = W'(DEBOUNCE_CYC - 1);
  localparam logic [W-1:0]   ONE  = W'(1);

  logic [W-1:0] cnt;

  // Count consecutive cycles the raw level differs from the filtered one; commit on the last.
  // NOTE: flops are written with <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (raw == filt) begin
      cnt  <= '0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      filt <= raw;
    end else begin
      cnt  <= cnt + ONE;
    end
  end

endmodule

// File: rtl/gate_sequencer.sv
// Parking gate sequencer: serves exit and entry requests, times the open and
// closing phases, and emits one direction-tagged event per completed passage.
module gate_sequencer
  import gate_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int OPEN_TIMEOUT = 1000,
  parameter int CLOSE_CYC    = 50
) (
  input  logic             clk,
  input  logic             reset,
  gate_sequencer_if.slave  bus
);

  localparam int           OW         = cnt_width(OPEN_TIMEOUT);
  localparam int           CW         = cnt_width(CLOSE_CYC);
  localparam logic [OW-1:0] OPEN_LAST  = OW'(OPEN_TIMEOUT - 1);
  localparam logic [CW-1:0] CLOSE_LAST = CW'(CLOSE_CYC - 1);
  localparam logic [OW-1:0] OPEN_ONE   = OW'(1);
  localparam logic [CW-1:0] CLOSE_ONE  = CW'(1);

  gate_state_e   state, state_nxt;
  logic [OW-1:0] open_cnt;
  logic [CW-1:0] close_cnt;

  logic entry_filt, exit_filt, pass_filt, pass_prev;
  logic pass_rise, pass_fall;
  logic deny_armed;

  logic gate_open_q, evt_pulse_q, evt_dir_q, deny_q, busy_q;
  logic evt_nxt, deny_nxt, dir_nxt;

  debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_entry_db (
    .clk (clk), .reset (reset), .raw (bus.entry_req),   .filt (entry_filt)
  );
  debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_exit_db (
    .clk (clk), .reset (reset), .raw (bus.exit_req),    .filt (exit_filt)
  );
  debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_pass_db (
    .clk (clk), .reset (reset), .raw (bus.pass_sensor), .filt (pass_filt)
  );

  assign pass_rise =  pass_filt & ~pass_prev;
  assign pass_fall = ~pass_filt &  pass_prev;

  // Next-state and next-output decode; exit wins over entry, beam events win over timers.
  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    evt_nxt   = 1'b0;
    deny_nxt  = 1'b0;
    dir_nxt   = evt_dir_q;
    case (state)
      IDLE: begin
        if (exit_filt) begin
          state_nxt = OPEN;
          dir_nxt   = DIR_OUT;
        end else if (entry_filt && !bus.full) begin
          state_nxt = OPEN;
          dir_nxt   = DIR_IN;
        end else if (entry_filt && deny_armed) begin
          deny_nxt  = 1'b1;
        end
      end
      OPEN: begin
        if (pass_rise)                  state_nxt = PASSING;
        else if (open_cnt == OPEN_LAST) state_nxt = CLOSING;
      end
      PASSING: begin
        if (pass_fall) begin
          state_nxt = CLOSING;
          evt_nxt   = 1'b1;
        end
      end
      CLOSING: begin
        if (pass_rise)                    state_nxt = PASSING;
        else if (close_cnt == CLOSE_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, edge history and registered outputs derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pass_prev   <= 1'b0;
      gate_open_q <= 1'b0;
      evt_pulse_q <= 1'b0;
      evt_dir_q   <= 1'b0;
      deny_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      pass_prev   <= pass_filt;
      gate_open_q <= (state_nxt == OPEN) || (state_nxt == PASSING);
      evt_pulse_q <= evt_nxt;
      evt_dir_q   <= dir_nxt;
      deny_q      <= deny_nxt;
      busy_q      <= (state_nxt != IDLE);
    end
  end

  // One deny per entry request: re-armed only once the filtered entry level drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           deny_armed <= 1'b1;
    else if (!entry_filt) deny_armed <= 1'b1;
    else if (deny_nxt)    deny_armed <= 1'b0;
  end

  // Phase timers: cleared on any state change, saturating while their phase lasts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      open_cnt  <= '0;
      close_cnt <= '0;
    end else if (state_nxt != state) begin
      open_cnt  <= '0;
      close_cnt <= '0;
    end else begin
      if (state == OPEN && open_cnt != OPEN_LAST)      open_cnt  <= open_cnt + OPEN_ONE;
      if (state == CLOSING && close_cnt != CLOSE_LAST) close_cnt <= close_cnt + CLOSE_ONE;
    end
  end

  assign bus.gate_open = gate_open_q;
  assign bus.evt_pulse = evt_pulse_q;
  assign bus.evt_dir   = evt_dir_q;
  assign bus.deny      = deny_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_gate_sequencer.sv
// Directed testbench for gate_sequencer with short timers.
module tb_gate_sequencer;
  localparam int DEB = 4;
  localparam int TMO = 20;
  localparam int CLS = 5;

  logic clk = 1'b0;
  logic reset;

  gate_sequencer_if bus ();

  gate_sequencer #(
    .DEBOUNCE_CYC (DEB),
    .OPEN_TIMEOUT (TMO),
    .CLOSE_CYC    (CLS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checks    = 0;
  int   errors    = 0;
  int   pulse_cnt = 0;
  int   deny_cnt  = 0;
  logic prev_dir;

  // Background monitor: counts strobes, checks exclusivity and direction setup.
  always @(negedge clk) begin
    if (bus.evt_pulse === 1'b1 || bus.deny === 1'b1) begin
      checks++;
      if (bus.evt_pulse === 1'b1 && bus.deny === 1'b1) begin
        errors++;
        $display("FAIL pulse_deny_overlap evt_pulse=%b deny=%b expected not both", bus.evt_pulse, bus.deny);
      end
    end
    if (bus.evt_pulse === 1'b1) begin
      pulse_cnt++;
      checks++;
      if (bus.evt_dir !== prev_dir) begin
        errors++;
        $display("FAIL dir_setup evt_dir=%b previous cycle=%b expected equal", bus.evt_dir, prev_dir);
      end
    end
    if (bus.deny === 1'b1) deny_cnt++;
    prev_dir = bus.evt_dir;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_gate(input logic val, input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget && lat < 0; i++) begin
      @(negedge clk);
      if (bus.gate_open === val) lat = i;
    end
  endtask

  task automatic wait_pulse(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget && lat < 0; i++) begin
      @(negedge clk);
      if (bus.evt_pulse === 1'b1) lat = i;
    end
  endtask

  task automatic wait_idle(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget && lat < 0; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) lat = i;
    end
  endtask

  // Beam broken for 'hold' cycles then cleared; returns pulse latency, direction and close time.
  task automatic do_passage(input int hold, output int p_lat, output logic dir, output int i_lat);
    bus.pass_sensor = 1'b1;
    tick(hold);
    bus.pass_sensor = 1'b0;
    wait_pulse(20, p_lat);
    dir = bus.evt_dir;
    wait_idle(20, i_lat);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.entry_req = 1'b0; bus.exit_req = 1'b0; bus.pass_sensor = 1'b0; bus.full = 1'b0;
    tick(3);
    checks++;
    if ({bus.gate_open, bus.evt_pulse, bus.evt_dir, bus.deny, bus.busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b expected=00000",
               {bus.gate_open, bus.evt_pulse, bus.evt_dir, bus.deny, bus.busy});
    end
    reset = 1'b0;
    tick(3);
    checks++;
    if (bus.busy !== 1'b0 || bus.gate_open !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle busy=%b gate_open=%b expected 0 0", bus.busy, bus.gate_open);
    end
  endtask

  task automatic test_entry;
    int lat, p_lat, i_lat, p0;
    logic dir;
    p0 = pulse_cnt;
    bus.entry_req = 1'b1;
    wait_gate(1'b1, 20, lat);
    checks++;
    if (lat != DEB + 1) begin
      errors++;
      $display("FAIL entry_open_latency got=%0d expected=%0d", lat, DEB + 1);
    end
    checks++;
    if (bus.evt_dir !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL entry_dir_busy evt_dir=%b busy=%b expected 1 1", bus.evt_dir, bus.busy);
    end
    tick(5);
    bus.entry_req = 1'b0;
    do_passage(8, p_lat, dir, i_lat);
    checks++;
    if (p_lat != DEB + 1 || dir !== 1'b1) begin
      errors++;
      $display("FAIL entry_pulse latency=%0d dir=%b expected %0d 1", p_lat, dir, DEB + 1);
    end
    checks++;
    if (i_lat != CLS) begin
      errors++;
      $display("FAIL entry_close_time got=%0d expected=%0d", i_lat, CLS);
    end
    tick(2);
    checks++;
    if (pulse_cnt - p0 != 1 || bus.gate_open !== 1'b0) begin
      errors++;
      $display("FAIL entry_pulse_count got=%0d gate_open=%b expected 1 0", pulse_cnt - p0, bus.gate_open);
    end
  endtask

  task automatic test_full;
    int lat, p_lat, i_lat, p0, d0;
    logic dir;
    logic seen_open;
    p0 = pulse_cnt; d0 = deny_cnt; seen_open = 1'b0;
    bus.full = 1'b1;
    bus.entry_req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      seen_open |= bus.gate_open;
    end
    checks++;
    if (deny_cnt - d0 != 1) begin
      errors++;
      $display("FAIL full_deny_count got=%0d expected=1", deny_cnt - d0);
    end
    checks++;
    if (seen_open !== 1'b0 || pulse_cnt != p0) begin
      errors++;
      $display("FAIL full_gate_stays_closed opened=%b pulses=%0d expected 0 0", seen_open, pulse_cnt - p0);
    end
    bus.entry_req = 1'b0;
    tick(6);
    bus.exit_req = 1'b1;
    wait_gate(1'b1, 20, lat);
    checks++;
    if (lat != DEB + 1 || bus.evt_dir !== 1'b0) begin
      errors++;
      $display("FAIL full_exit_open latency=%0d dir=%b expected %0d 0", lat, bus.evt_dir, DEB + 1);
    end
    bus.exit_req = 1'b0;
    do_passage(8, p_lat, dir, i_lat);
    checks++;
    if (p_lat < 0 || dir !== 1'b0 || i_lat != CLS) begin
      errors++;
      $display("FAIL full_exit_passage p_lat=%0d dir=%b i_lat=%0d expected pulse 0 %0d", p_lat, dir, i_lat, CLS);
    end
    bus.full = 1'b0;
    tick(2);
  endtask

  task automatic test_simultaneous;
    int lat, p_lat, i_lat, p0;
    logic dir;
    p0 = pulse_cnt;
    bus.entry_req = 1'b1;
    bus.exit_req  = 1'b1;
    wait_gate(1'b1, 20, lat);
    checks++;
    if (lat < 0 || bus.evt_dir !== 1'b0) begin
      errors++;
      $display("FAIL simul_first_dir latency=%0d dir=%b expected open 0", lat, bus.evt_dir);
    end
    bus.exit_req = 1'b0;
    do_passage(8, p_lat, dir, i_lat);
    checks++;
    if (p_lat < 0 || dir !== 1'b0) begin
      errors++;
      $display("FAIL simul_first_pulse p_lat=%0d dir=%b expected pulse 0", p_lat, dir);
    end
    wait_gate(1'b1, 20, lat);
    checks++;
    if (lat < 0 || bus.evt_dir !== 1'b1) begin
      errors++;
      $display("FAIL simul_second_dir latency=%0d dir=%b expected open 1", lat, bus.evt_dir);
    end
    bus.entry_req = 1'b0;
    do_passage(8, p_lat, dir, i_lat);
    tick(2);
    checks++;
    if (p_lat < 0 || dir !== 1'b1 || pulse_cnt - p0 != 2) begin
      errors++;
      $display("FAIL simul_second_pulse p_lat=%0d dir=%b pulses=%0d expected pulse 1 2", p_lat, dir, pulse_cnt - p0);
    end
  endtask

  task automatic test_timeout;
    int lat, open_cyc, i_lat, p0;
    p0 = pulse_cnt;
    bus.exit_req = 1'b1;
    wait_gate(1'b1, 20, lat);
    bus.exit_req = 1'b0;
    open_cyc = (lat < 0) ? 0 : 1;
    for (int i = 0; i < 60 && bus.gate_open === 1'b1; i++) begin
      tick(1);
      if (bus.gate_open === 1'b1) open_cyc++;
    end
    checks++;
    if (open_cyc != TMO) begin
      errors++;
      $display("FAIL timeout_open_cycles got=%0d expected=%0d", open_cyc, TMO);
    end
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_closing_busy got=%b expected=1", bus.busy);
    end
    wait_idle(20, i_lat);
    tick(2);
    checks++;
    if (i_lat != CLS || pulse_cnt != p0) begin
      errors++;
      $display("FAIL timeout_close i_lat=%0d pulses=%0d expected %0d 0", i_lat, pulse_cnt - p0, CLS);
    end
  endtask

  task automatic test_glitch_tailgate;
    int lat, p_lat, i_lat, p0;
    logic dir;
    p0 = pulse_cnt;
    bus.exit_req = 1'b1;
    wait_gate(1'b1, 20, lat);
    bus.exit_req = 1'b0;
    tick(2);
    bus.pass_sensor = 1'b1;
    tick(2);
    bus.pass_sensor = 1'b0;
    tick(6);
    checks++;
    if (bus.gate_open !== 1'b1 || pulse_cnt != p0) begin
      errors++;
      $display("FAIL glitch_ignored gate_open=%b pulses=%0d expected 1 0", bus.gate_open, pulse_cnt - p0);
    end
    bus.pass_sensor = 1'b1;
    tick(8);
    bus.pass_sensor = 1'b0;
    wait_pulse(20, p_lat);
    checks++;
    if (p_lat != DEB + 1 || bus.evt_dir !== 1'b0 || bus.gate_open !== 1'b0) begin
      errors++;
      $display("FAIL tailgate_first_pulse p_lat=%0d dir=%b gate_open=%b expected %0d 0 0",
               p_lat, bus.evt_dir, bus.gate_open, DEB + 1);
    end
    bus.pass_sensor = 1'b1;
    wait_gate(1'b1, 20, lat);
    checks++;
    if (lat != DEB + 1) begin
      errors++;
      $display("FAIL tailgate_reopen latency=%0d expected=%0d", lat, DEB + 1);
    end
    do_passage(4, p_lat, dir, i_lat);
    tick(2);
    checks++;
    if (p_lat < 0 || dir !== 1'b0 || i_lat != CLS || pulse_cnt - p0 != 2) begin
      errors++;
      $display("FAIL tailgate_second_pulse p_lat=%0d dir=%b i_lat=%0d pulses=%0d expected pulse 0 %0d 2",
               p_lat, dir, i_lat, pulse_cnt - p0, CLS);
    end
  endtask

  task automatic test_reset_passing;
    int lat, p_lat, i_lat, p0;
    logic dir;
    bus.entry_req = 1'b1;
    wait_gate(1'b1, 20, lat);
    bus.entry_req = 1'b0;
    bus.pass_sensor = 1'b1;
    tick(7);
    p0 = pulse_cnt;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.gate_open !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_gate got=%b expected=0", bus.gate_open);
    end
    checks++;
    if ({bus.evt_pulse, bus.evt_dir, bus.deny, bus.busy} !== 4'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs got=%b expected=0000", {bus.evt_pulse, bus.evt_dir, bus.deny, bus.busy});
    end
    tick(2);
    reset = 1'b0;
    tick(3);
    bus.pass_sensor = 1'b0;
    tick(10);
    checks++;
    if (pulse_cnt != p0 || bus.gate_open !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_pulse pulses=%0d gate_open=%b busy=%b expected 0 0 0",
               pulse_cnt - p0, bus.gate_open, bus.busy);
    end
    bus.entry_req = 1'b1;
    wait_gate(1'b1, 20, lat);
    checks++;
    if (lat != DEB + 1 || bus.evt_dir !== 1'b1) begin
      errors++;
      $display("FAIL reset_then_entry latency=%0d dir=%b expected %0d 1", lat, bus.evt_dir, DEB + 1);
    end
    bus.entry_req = 1'b0;
    do_passage(8, p_lat, dir, i_lat);
    tick(2);
    checks++;
    if (p_lat < 0 || dir !== 1'b1 || pulse_cnt - p0 != 1) begin
      errors++;
      $display("FAIL reset_then_pulse p_lat=%0d dir=%b pulses=%0d expected pulse 1 1", p_lat, dir, pulse_cnt - p0);
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_full();
    test_simultaneous();
    test_timeout();
    test_glitch_tailgate();
    test_reset_passing();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gate_sequencer.md
GATE_SEQUENCER -- requirements
Module: gate_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 4: consecutive stable cycles required before a filtered input changes.
REQ-002 Parameter OPEN_TIMEOUT, default 1000: cycles the gate stays open waiting for a car before aborting.
REQ-003 Parameter CLOSE_CYC, default 50: gate closing travel time in cycles.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 reset  in  1  reset, asynchronous, active-high.
REQ-006 entry_req  in  1  entry-loop detector level, 1 = car waiting to enter.
REQ-007 exit_req  in  1  exit-loop detector level, 1 = car waiting to leave.
REQ-008 pass_sensor  in  1  gate beam level, 1 = beam broken by car.
REQ-009 full  in  1  occupancy-counter status, 1 = garage full.
REQ-010 gate_open  out  1  gate motor drive, 1 = open/hold open.
REQ-011 evt_pulse  out  1  one-cycle strobe per completed passage; drives the counter's event-clock input.
REQ-012 evt_dir  out  1  passage direction, 1 = in, 0 = out; drives the counter's direction input.
REQ-013 deny  out  1  one-cycle strobe, entry refused because full.
REQ-014 busy  out  1  1 whenever state is not IDLE.

Function
REQ-015 entry_req, exit_req, pass_sensor each SHALL be debounced: filtered level takes a new value only after the raw input has held it for DEBOUNCE_CYC consecutive cycles; edges are detected on filtered levels.
REQ-016 States SHALL be IDLE, OPEN, PASSING, CLOSING.
REQ-017 IDLE: filtered exit_req = 1 -> evt_dir <= 0, gate_open <= 1, go OPEN.
REQ-018 IDLE: filtered entry_req = 1, exit not requested, full = 0 -> evt_dir <= 1, gate_open <= 1, go OPEN.
REQ-019 IDLE: both requests in the same cycle -> exit served first; entry served on the next return to IDLE if still asserted.
REQ-020 IDLE: filtered entry_req rising edge while full = 1 -> deny = 1 for exactly one cycle, stay IDLE; no re-deny until entry_req falls and rises again.
REQ-021 OPEN: filtered pass_sensor rising -> PASSING; OPEN_TIMEOUT cycles elapse in OPEN without it -> CLOSING, no event.
REQ-022 PASSING: filtered pass_sensor falling -> evt_pulse = 1 for exactly one cycle, go CLOSING.
REQ-023 CLOSING: gate_open = 0; after CLOSE_CYC cycles -> IDLE.
REQ-024 CLOSING: filtered pass_sensor rising (tailgater/safety) -> gate_open <= 1, go PASSING, evt_dir unchanged, closing timer cleared; its falling edge issues a further evt_pulse regardless of full.
REQ-025 evt_dir SHALL change only on entry to OPEN, be stable at least one cycle before and throughout evt_pulse, and hold its value until the next OPEN.
REQ-026 evt_pulse and deny SHALL never be asserted in the same cycle; at most one evt_pulse per PASSING visit.
REQ-027 Timers SHALL be sized for their parameter value and saturate, never wrap.
REQ-028 full is sampled only in IDLE; changes of full in other states SHALL not affect the current passage.

Reset
REQ-029 On reset: state IDLE, gate_open 0, evt_pulse 0, evt_dir 0, deny 0, busy 0, all timers 0, filtered levels 0.
REQ-030 Reset asserted mid-passage SHALL drop gate_open immediately and SHALL emit no evt_pulse, including on deassertion.

Structure
REQ-031 Shared package gate_pkg SHALL hold the state enumeration and constants DIR_IN = 1, DIR_OUT = 0.
REQ-032 One sub-module, debounce (parameter DEBOUNCE_CYC, ports clk, reset, raw, filt), SHALL be instantiated three times.

Verification (DEBOUNCE_CYC=4, OPEN_TIMEOUT=20, CLOSE_CYC=5)
REQ-033 Entry, full=0: entry_req high 10 cycles, pass_sensor high 8 cycles then low -> gate_open 1, evt_dir 1, one evt_pulse, gate_open 0, IDLE after 5 closing cycles.
REQ-034 Full: full=1, entry_req high -> one deny pulse, gate_open stays 0, no evt_pulse; exit_req then served normally with evt_dir 0.
REQ-035 Simultaneous entry_req and exit_req, full=0 -> first passage evt_dir 0, second passage evt_dir 1, two evt_pulses total.
REQ-036 Timeout: exit_req high, no pass_sensor -> gate closes after 20 open cycles, no evt_pulse, IDLE after 5 more.
REQ-037 Glitch/tailgate: pass_sensor 2-cycle glitch -> ignored; pass_sensor rising during CLOSING -> gate_open back to 1, second evt_pulse, same evt_dir.
REQ-038 Reset in PASSING -> gate_open 0 same cycle, no evt_pulse, all outputs 0, normal entry afterwards.
